// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one uart_tx serializer among
// NUM_REQ byte producers. One byte is in flight at a time. A byte is issued
// with a single tx_start pulse, and the arbiter then waits for tx_busy to
// rise and fall before it grants again.
// Optional feature macro: UART_TX_ARB_TAG_EN. When it is defined, a tag byte
// (TAG_BASE | channel) is sent before the data byte whenever the channel
// changes, and before the first byte after reset.
module uart_tx_arbiter #(
    parameter int         NUM_REQ  = 4,
    parameter logic [7:0] TAG_BASE = 8'hA0
) (
    input  logic                       clk,
    input  logic                       rst_,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*8-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    input  logic                       tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       active
);
    localparam int IDW = $clog2(NUM_REQ);

    // Reject illegal configurations at elaboration time.
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("uart_tx_arbiter: NUM_REQ must be 2..8");
    end
    if (TAG_BASE[2:0] != 3'b000) begin : g_bad_tag_base
        $error("uart_tx_arbiter: TAG_BASE[2:0] must be zero");
    end

    typedef enum logic [2:0] {
        ARB, ISSUE, WAIT_BUSY, WAIT_DONE
`ifdef UART_TX_ARB_TAG_EN
        , TAG_ISSUE, TAG_WAIT_BUSY, TAG_WAIT_DONE
`endif
    } state_t;

    state_t           state;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   win_idx;
    logic [IDW-1:0]   ptr_nxt;
    logic [7:0]       win_byte;
    logic [NUM_REQ-1:0] win_oh;
    int               best_off;
    int               off;

`ifdef UART_TX_ARB_TAG_EN
    logic [7:0]       hold;
    logic [IDW-1:0]   last_ch;
    logic             last_vld;
`endif

    // Winner: the valid requester whose distance from ptr (mod NUM_REQ) is the smallest.
    always_comb begin
        win_idx  = '0;
        win_byte = '0;
        best_off = NUM_REQ;
        off      = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            off = (j + NUM_REQ - int'(ptr)) % NUM_REQ;
            if (req_valid[j] && off < best_off) begin
                best_off = off;
                win_idx  = IDW'(j);
                win_byte = req_data[8*j +: 8];
            end
        end
    end

    assign ptr_nxt = (win_idx == IDW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    assign win_oh  = NUM_REQ'(1) << win_idx;
    assign active  = (state != ARB);

    // Control FSM; tx_start and req_ready are single-cycle registered pulses.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state     <= ARB;
            ptr       <= '0;
            grant_id  <= '0;
            tx_start  <= 1'b0;
            tx_data   <= '0;
            req_ready <= '0;
`ifdef UART_TX_ARB_TAG_EN
            hold      <= '0;
            last_ch   <= '0;
            last_vld  <= 1'b0;
`endif
        end else begin
            tx_start  <= 1'b0;
            req_ready <= '0;
            case (state)
                ARB: begin
                    if (!tx_busy && |req_valid) begin
                        grant_id <= win_idx;
                        ptr      <= ptr_nxt;
                        tx_start <= 1'b1;
`ifdef UART_TX_ARB_TAG_EN
                        hold     <= win_byte;
                        if (!last_vld || last_ch != win_idx) begin
                            tx_data <= TAG_BASE | 8'(win_idx);
                            state   <= TAG_ISSUE;
                        end else begin
                            tx_data   <= win_byte;
                            req_ready <= win_oh;
                            state     <= ISSUE;
                        end
`else
                        tx_data   <= win_byte;
                        req_ready <= win_oh;
                        state     <= ISSUE;
`endif
                    end
                end
                ISSUE: begin
`ifdef UART_TX_ARB_TAG_EN
                    last_ch  <= grant_id;
                    last_vld <= 1'b1;
`endif
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: if (tx_busy) state <= WAIT_DONE;
                WAIT_DONE: if (!tx_busy) state <= ARB;
`ifdef UART_TX_ARB_TAG_EN
                TAG_ISSUE:     state <= TAG_WAIT_BUSY;
                TAG_WAIT_BUSY: if (tx_busy) state <= TAG_WAIT_DONE;
                TAG_WAIT_DONE: begin
                    // Tag is out; issue the held data byte straight away.
                    if (!tx_busy) begin
                        tx_start  <= 1'b1;
                        tx_data   <= hold;
                        req_ready <= NUM_REQ'(1) << grant_id;
                        state     <= ISSUE;
                    end
                end
`endif
                default: state <= ARB;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a uart_tx busy model, a
// transaction-level reference model (one byte in flight, round-robin
// choice), directed cases, and a randomized phase.
module tb_uart_tx_arbiter;
    localparam int         N    = 4;
    localparam int         IW   = $clog2(N);
    localparam logic [7:0] TAGB = 8'hA0;

    logic           clk = 1'b0;
    logic           rst_ = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*8-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_busy = 1'b0;
    logic [IW-1:0]  grant_id;
    logic           active;

    int tests = 0;
    int fails = 0;

    uart_tx_arbiter #(.NUM_REQ(N), .TAG_BASE(TAGB)) dut (
        .clk(clk), .rst_(rst_), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .grant_id(grant_id), .active(active)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // uart_tx stand-in: busy rises the cycle after tx_start, lasts 2..10 cycles.
    int         bcnt = 0;
    logic [7:0] sent[$];
    always @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            tx_busy <= 1'b0;
            bcnt = 0;
        end else if (tx_start) begin
            tests++;
            if (tx_busy) begin
                fails++;
                $display("FAIL start_while_busy: got tx_start=1 expected 0 while busy");
            end
            sent.push_back(tx_data);
            bcnt = $urandom_range(2, 10);
            tx_busy <= 1'b1;
        end else if (tx_busy) begin
            bcnt--;
            if (bcnt == 0) tx_busy <= 1'b0;
        end
    end

    // Reference model: bytes queued per grant, one launched at a time.
    int         m_ptr = 0, m_w = 0, m_last = -1;
    bit         m_fly = 0, m_seen = 0;
    logic [7:0] pb[$];
    logic [N-1:0] pm[$];
    logic       e_start = 0;
    logic [7:0] e_data = 0;
    logic [N-1:0] e_ready = 0;
    int         e_grant = 0;
    bit         e_active = 0;
    always @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            m_ptr = 0; m_fly = 0; m_seen = 0; m_last = -1;
            pb.delete(); pm.delete();
            e_start = 0; e_data = 0; e_ready = '0; e_grant = 0; e_active = 0;
        end else begin
            e_start = 0;
            e_ready = '0;
            if (m_fly) begin
                if (m_seen && !tx_busy) begin
                    m_fly = 0;
                    m_seen = 0;
                    if (pb.size() > 0) begin
                        e_start = 1; e_data = pb.pop_front(); e_ready = pm.pop_front(); m_fly = 1;
                    end
                end else if (tx_busy) begin
                    m_seen = 1;
                end
            end else if (!tx_busy && req_valid != '0) begin
                m_w = -1;
                for (int i = 0; i < N; i++)
                    if (m_w < 0 && req_valid[(m_ptr + i) % N]) m_w = (m_ptr + i) % N;
                m_ptr = (m_w + 1) % N;
                e_grant = m_w;
`ifdef UART_TX_ARB_TAG_EN
                if (m_last != m_w) begin
                    pb.push_back(TAGB | 8'(m_w));
                    pm.push_back('0);
                end
                m_last = m_w;
`endif
                pb.push_back(req_data[8*m_w +: 8]);
                pm.push_back(N'(1) << m_w);
                e_start = 1; e_data = pb.pop_front(); e_ready = pm.pop_front(); m_fly = 1;
            end
            e_active = m_fly || (pb.size() > 0);
        end
    end

    // Cycle compare against the model, plus a fairness bound on observed grants.
    int skips[N];
    always @(negedge clk) begin
        check("outputs", {tx_start, req_ready, tx_data, 8'(grant_id), active},
                         {e_start, e_ready, e_data, 8'(e_grant), e_active});
        if (!rst_) begin
            for (int j = 0; j < N; j++) skips[j] = 0;
        end else if (req_ready != '0) begin
            for (int j = 0; j < N; j++) begin
                if (j == int'(grant_id)) skips[j] = 0;
                else if (req_valid[j]) begin
                    skips[j]++;
                    check("fairness_skips", 64'(skips[j] <= N - 1), 64'(1));
                end
            end
        end
    end

    task automatic wait_ready();
        bit ok = 0;
        for (int c = 0; c < 400 && !ok; c++) begin
            @(negedge clk);
            if (req_ready != '0) ok = 1;
        end
        if (!ok) fail_now("ready_timeout");
        #1;
    endtask

    task automatic wait_busy(input bit lvl);
        bit ok = 0;
        for (int c = 0; c < 400 && !ok; c++) begin
            @(negedge clk);
            if (tx_busy == lvl) ok = 1;
        end
        if (!ok) fail_now("busy_timeout");
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int c = 0; c < 600 && !ok; c++) begin
            @(negedge clk);
            if (!active && !tx_busy) ok = 1;
        end
        if (!ok) fail_now("idle_timeout");
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst_ = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        rst_ = 1'b1;
    endtask

    task automatic rnd_phase(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    if (c < cycles - 250 && $urandom_range(0, 1) == 1) req_data[8*i +: 8] = 8'($urandom);
                    else req_valid[i] = 1'b0;
                end else if (!req_valid[i] && c < cycles - 250 && $urandom_range(0, 3) == 0) begin
                    req_valid[i] = 1'b1;
                    req_data[8*i +: 8] = 8'($urandom);
                end
            end
        end
    endtask

    initial begin
        #400_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int d;
        bit seen;
        // Reset with idle inputs.
        #1 rst_ = 1'b0;
        @(negedge clk);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_active", active, 0);
        #1 rst_ = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_active", active, 0);
        check("idle_tx_start", tx_start, 0);
        #1;

        // Requester 2 alone with 0x55.
        req_valid = 4'b0100;
        req_data[23:16] = 8'h55;
        wait_ready();
        check("r2_tx_start", tx_start, 1);
        check("r2_tx_data", tx_data, 8'h55);
        check("r2_req_ready", req_ready, 4'b0100);
        check("r2_grant_id", grant_id, 2);
        req_valid = '0;
        @(negedge clk);
        check("r2_ready_one_cycle", req_ready, 0);
        check("r2_start_one_cycle", tx_start, 0);
        wait_idle();

        // All four held valid: grant order 0,1,2,3,0 from a fresh pointer.
        do_reset();
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_ready();
            check("rr_grant", grant_id, exp_order[k]);
            check("rr_data", tx_data, 8'h10 + 8'(exp_order[k]));
        end
        req_valid = '0;
        wait_idle();

        // Requester 1 shows up mid-frame of requester 0.
        do_reset();
        req_valid = 4'b0001;
        req_data[7:0] = 8'h20;
        wait_ready();
        req_valid = '0;
        wait_busy(1'b1);
        #1;
        req_valid[1] = 1'b1;
        req_data[15:8] = 8'h31;
        wait_busy(1'b0);
        d = 0;
        seen = 0;
        for (int c = 1; c < 50 && !seen; c++) begin
            @(negedge clk);
            if (tx_start) begin
                seen = 1;
                d = c;
            end
        end
        check("mid_start_delay", d, 2);
        check("mid_grant", grant_id, 1);
        wait_ready();
        req_valid = '0;
        wait_idle();

        // Channel tag sequence: 3:C4, 3:C4, 0:7E.
        do_reset();
        sent.delete();
        req_valid = 4'b1000;
        req_data[31:24] = 8'hC4;
        wait_ready();
        check("tag_ready1", req_ready, 4'b1000);
        wait_ready();
        check("tag_ready2", req_ready, 4'b1000);
        req_valid = 4'b0001;
        req_data[7:0] = 8'h7E;
        wait_ready();
        check("tag_ready3", req_ready, 4'b0001);
        req_valid = '0;
        wait_idle();
`ifdef UART_TX_ARB_TAG_EN
        check("tag_stream_len", sent.size(), 5);
        if (sent.size() == 5)
            check("tag_stream", {sent[0], sent[1], sent[2], sent[3], sent[4]}, 40'hA3_C4_C4_A0_7E);
`else
        check("tag_stream_len", sent.size(), 3);
        if (sent.size() == 3)
            check("tag_stream", {sent[0], sent[1], sent[2]}, 24'hC4_C4_7E);
`endif

        // Randomized traffic against the model.
        rnd_phase(3000);
        req_valid = '0;
        wait_idle();

        // Reset while waiting for the frame to finish.
        req_valid = 4'b0001;
        req_data[7:0] = 8'h5A;
        wait_ready();
        req_valid = '0;
        wait_busy(1'b1);
        @(negedge clk);
        check("midrst_active_before", active, 1);
        #1 rst_ = 1'b0;
        #1;
        check("midrst_active", active, 0);
        check("midrst_tx_start", tx_start, 0);
        check("midrst_req_ready", req_ready, 0);
        repeat (2) @(negedge clk);
        #1 rst_ = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_active", active, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
